mm_seq_ctrl: RTL and testbench

- Sequencer for the matrix-multiply datapath inside mmmain_top.
- Walks every output element C[i][j] of an N×N product.
- Per element: issues A/B operand reads, drives MAC enable and clear aligned to the memory read latency, then pulses the C write.
- Runs from a single start pulse and reports busy and done.

---
 rtl/mm_pkg.sv | 17 +
 rtl/mm_rd_delay.sv | 44 ++++
 rtl/mm_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mm_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and default geometry for the matrix-multiply sequencer.
// Consumers: mm_seq_ctrl, mm_rd_delay.
package mm_pkg;

    localparam int MM_N      = 4;
    localparam int MM_RD_LAT = 1;
    localparam int MM_AW     = $clog2(MM_N * MM_N);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/mm_rd_delay.sv
// RD_LAT-stage shift register carrying {valid, first} from the read issue
// point to the MAC input, so MAC strobes line up with returning operand data.
module mm_rd_delay #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_i,
    input  logic first_i,
    output logic valid_o,
    output logic first_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] first_q;
    logic [RD_LAT-1:0] valid_d;
    logic [RD_LAT-1:0] first_d;

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign valid_d[gi] = valid_i;
                assign first_d[gi] = first_i;
            end else begin : g_tail
                assign valid_d[gi] = valid_q[gi-1];
                assign first_d[gi] = first_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            first_q <= '0;
        end else begin
            valid_q <= valid_d;
            first_q <= first_d;
        end
    end

    assign valid_o = valid_q[RD_LAT-1];
    assign first_o = first_q[RD_LAT-1];

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencer walking every C[i][j] of an N x N product: operand reads, MAC
// strobes aligned to read latency, C write. Optional busy-cycle counter: MM_CTRL_PERF_EN.
module mm_seq_ctrl
    import mm_pkg::*;
#(
    parameter int N      = MM_N,
    parameter int RD_LAT = MM_RD_LAT,
    parameter int AW     = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          a_re,
    output logic          b_re,
    output logic          mac_en,
    output logic          mac_clr,
    output logic [AW-1:0] c_addr,
    output logic          c_we,
    output logic [15:0]   perf_cycles
);

    localparam int IW = $clog2(N);
    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t          state_q;
    logic [IW-1:0]   i_q;
    logic [IW-1:0]   j_q;
    logic [IW-1:0]   k_q;
    logic [WW-1:0]   wcnt_q;
    logic            busy_q;
    logic            done_q;
    logic            a_re_q;
    logic            first_q;
    logic            c_we_q;
    logic [AW-1:0]   a_addr_q;
    logic [AW-1:0]   b_addr_q;
    logic [AW-1:0]   c_addr_q;

    logic [IW-1:0]   k_inc;
    logic [IW-1:0]   i_nx;
    logic [IW-1:0]   j_nx;
    logic            k_last;
    logic            j_last;
    logic            i_last;

    function automatic logic [AW-1:0] lin(input logic [IW-1:0] row,
                                          input logic [IW-1:0] col);
        return AW'(row) * AW'(N) + AW'(col);
    endfunction

    // Indices of the element following the current one (row-major order).
    always_comb begin
        k_inc  = k_q + IW'(1);
        k_last = (k_q == IW'(N - 1));
        j_last = (j_q == IW'(N - 1));
        i_last = (i_q == IW'(N - 1));
        j_nx   = j_last ? '0 : j_q + IW'(1);
        i_nx   = j_last ? (i_last ? '0 : i_q + IW'(1)) : i_q;
    end

    // Outputs are loaded on the same edge as the state they belong to, so
    // every output is a flop and describes the state currently held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            wcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_re_q   <= 1'b0;
            first_q  <= 1'b0;
            c_we_q   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
        end else begin
            a_re_q  <= 1'b0;
            first_q <= 1'b0;
            c_we_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= ISSUE;
                        busy_q   <= 1'b1;
                        i_q      <= '0;
                        j_q      <= '0;
                        k_q      <= '0;
                        a_re_q   <= 1'b1;
                        first_q  <= 1'b1;
                        a_addr_q <= '0;
                        b_addr_q <= '0;
                    end
                end
                ISSUE: begin
                    if (k_last) begin
                        state_q <= WAIT;
                        k_q     <= '0;
                        wcnt_q  <= '0;
                    end else begin
                        k_q      <= k_inc;
                        a_re_q   <= 1'b1;
                        a_addr_q <= lin(i_q, k_inc);
                        b_addr_q <= lin(k_inc, j_q);
                    end
                end
                WAIT: begin
                    if (wcnt_q == WW'(RD_LAT - 1)) begin
                        state_q  <= WRITE;
                        c_we_q   <= 1'b1;
                        c_addr_q <= lin(i_q, j_q);
                    end else begin
                        wcnt_q <= wcnt_q + WW'(1);
                    end
                end
                WRITE: begin
                    i_q <= i_nx;
                    j_q <= j_nx;
                    if (j_last && i_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= ISSUE;
                        a_re_q   <= 1'b1;
                        first_q  <= 1'b1;
                        a_addr_q <= lin(i_nx, IW'(0));
                        b_addr_q <= lin(IW'(0), j_nx);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // first_q is only ever set alongside a_re_q, so the delayed first is
    // already qualified by valid and drives mac_clr directly.
    mm_rd_delay #(
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .clk     (clk),
        .rst     (rst),
        .valid_i (a_re_q),
        .first_i (first_q),
        .valid_o (mac_en),
        .first_o (mac_clr)
    );

`ifdef MM_CTRL_PERF_EN
    logic [15:0] perf_q;

    // Holds after done so the last run's length stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_q <= '0;
        end else if (busy_q && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 16'h0000;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_addr = a_addr_q;
    assign b_addr = b_addr_q;
    assign a_re   = a_re_q;
    assign b_re   = a_re_q;
    assign c_addr = c_addr_q;
    assign c_we   = c_we_q;

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl: N=4/RD_LAT=1 instance plus an N=2/RD_LAT=3
// instance for the latency sweep. Cycle c = interval after the c-th edge following start.
module tb_mm_seq_ctrl;

    localparam int N0  = 4;
    localparam int RL0 = 1;
    localparam int AW0 = $clog2(N0 * N0);
    localparam int N1  = 2;
    localparam int RL1 = 3;
    localparam int AW1 = $clog2(N1 * N1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0;
    logic start1 = 1'b0;

    logic           busy0, done0, a_re0, b_re0, mac_en0, mac_clr0, c_we0;
    logic [AW0-1:0] a_addr0, b_addr0, c_addr0;
    logic [15:0]    perf0;
    logic           busy1, done1, a_re1, b_re1, mac_en1, mac_clr1, c_we1;
    logic [AW1-1:0] a_addr1, b_addr1, c_addr1;
    logic [15:0]    perf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mm_seq_ctrl #(.N(N0), .RD_LAT(RL0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .a_addr(a_addr0), .b_addr(b_addr0), .a_re(a_re0), .b_re(b_re0),
        .mac_en(mac_en0), .mac_clr(mac_clr0), .c_addr(c_addr0), .c_we(c_we0),
        .perf_cycles(perf0)
    );

    mm_seq_ctrl #(.N(N1), .RD_LAT(RL1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .a_addr(a_addr1), .b_addr(b_addr1), .a_re(a_re1), .b_re(b_re1),
        .mac_en(mac_en1), .mac_clr(mac_clr1), .c_addr(c_addr1), .c_we(c_we1),
        .perf_cycles(perf1)
    );

    task automatic do_reset;
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy0, done0, a_re0, b_re0, mac_en0, mac_clr0, c_we0} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl0 got=%b exp=0000000", {busy0, done0, a_re0, b_re0, mac_en0, mac_clr0, c_we0});
        end
        checks++;
        if ({a_addr0, b_addr0, c_addr0, perf0} !== '0) begin
            errors++;
            $display("FAIL reset_data0 got a=%0d b=%0d c=%0d perf=%0d exp all 0", a_addr0, b_addr0, c_addr0, perf0);
        end
        checks++;
        if ({busy1, done1, a_re1, b_re1, mac_en1, mac_clr1, c_we1, a_addr1, b_addr1, c_addr1, perf1} !== '0) begin
            errors++;
            $display("FAIL reset_dut1 got busy=%b a_re=%b c_we=%b perf=%0d exp all 0", busy1, a_re1, c_we1, perf1);
        end
        rst = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_single_element;
        bit are_t [7] = '{1, 1, 1, 1, 0, 0, 1};
        bit men_t [7] = '{0, 1, 1, 1, 1, 0, 0};
        bit clr_t [7] = '{0, 1, 0, 0, 0, 0, 0};
        bit we_t  [7] = '{0, 0, 0, 0, 0, 1, 0};
        int a_t   [7] = '{0, 1, 2, 3, 0, 0, 0};
        int b_t   [7] = '{0, 4, 8, 12, 0, 0, 1};
        int c;
        for (int t = 0; t < 7; t++) begin
            start0 = (t == 0);
            @(posedge clk);
            #1;
            c = t + 1;
            $display("single c=%0d a_re=%b a=%0d b=%0d mac_en=%b clr=%b c_we=%b c_addr=%0d",
                     c, a_re0, a_addr0, b_addr0, mac_en0, mac_clr0, c_we0, c_addr0);
            checks++;
            if ({a_re0, b_re0, mac_en0, mac_clr0, c_we0, busy0} !==
                {are_t[t], are_t[t], men_t[t], clr_t[t], we_t[t], 1'b1}) begin
                errors++;
                $display("FAIL single_ctrl c=%0d got=%b exp=%b", c,
                         {a_re0, b_re0, mac_en0, mac_clr0, c_we0, busy0},
                         {are_t[t], are_t[t], men_t[t], clr_t[t], we_t[t], 1'b1});
            end
            if (are_t[t]) begin
                checks++;
                if (a_addr0 !== AW0'(a_t[t]) || b_addr0 !== AW0'(b_t[t])) begin
                    errors++;
                    $display("FAIL single_addr c=%0d got a=%0d b=%0d exp a=%0d b=%0d", c, a_addr0, b_addr0, a_t[t], b_t[t]);
                end
            end
            if (we_t[t]) begin
                checks++;
                if (c_addr0 !== '0) begin
                    errors++;
                    $display("FAIL single_caddr c=%0d got=%0d exp=0", c, c_addr0);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_full_run(input int s1, input int s2, input string tag);
        int c, e, p, wcount, exp_perf;
        bit in_run, ex_are, ex_men, ex_clr, ex_we;
        wcount = 0;
        for (int t = 0; t < 100; t++) begin
            start0 = (t == 0) || (t == s1) || (t == s2);
            @(posedge clk);
            #1;
            c = t + 1;
            e = (c - 1) / 6;
            p = (c - 1) % 6;
            in_run = (c <= 96);
            ex_are = in_run && (p < 4);
            ex_men = in_run && (p >= 1) && (p <= 4);
            ex_clr = in_run && (p == 1);
            ex_we  = in_run && (p == 5);
            checks++;
            if ({busy0, done0, a_re0, b_re0, mac_en0, mac_clr0, c_we0} !==
                {in_run, (c == 97), ex_are, ex_are, ex_men, ex_clr, ex_we}) begin
                errors++;
                $display("FAIL %s_ctrl c=%0d got=%b exp=%b", tag, c,
                         {busy0, done0, a_re0, b_re0, mac_en0, mac_clr0, c_we0},
                         {in_run, (c == 97), ex_are, ex_are, ex_men, ex_clr, ex_we});
            end
            if (ex_are) begin
                checks++;
                if (a_addr0 !== AW0'((e / 4) * 4 + p) || b_addr0 !== AW0'(p * 4 + e % 4)) begin
                    errors++;
                    $display("FAIL %s_addr c=%0d got a=%0d b=%0d exp a=%0d b=%0d", tag, c,
                             a_addr0, b_addr0, (e / 4) * 4 + p, p * 4 + e % 4);
                end
            end
            if (c_we0 === 1'b1) wcount++;
            if (ex_we) begin
                $display("%s write c=%0d c_addr=%0d", tag, c, c_addr0);
                checks++;
                if (c_addr0 !== AW0'(e)) begin
                    errors++;
                    $display("FAIL %s_caddr c=%0d got=%0d exp=%0d", tag, c, c_addr0, e);
                end
            end
`ifdef MM_CTRL_PERF_EN
            exp_perf = (c - 1 < 96) ? c - 1 : 96;
`else
            exp_perf = 0;
`endif
            checks++;
            if (perf0 !== 16'(exp_perf)) begin
                errors++;
                $display("FAIL %s_perf c=%0d got=%0d exp=%0d", tag, c, perf0, exp_perf);
            end
        end
        start0 = 1'b0;
        checks++;
        if (wcount != 16) begin
            errors++;
            $display("FAIL %s_wcount got=%0d exp=16", tag, wcount);
        end
        do_reset();
    endtask

    task automatic test_start_while_busy;
        test_full_run(10, 50, "busy_start");
    endtask

    task automatic test_reset_mid_run;
        int c;
        for (int t = 0; t < 60; t++) begin
            start0 = (t == 0);
            rst = (t == 40);
            @(posedge clk);
            #1;
            c = t + 1;
            if (c == 41) begin
                $display("midrst c=%0d busy=%b a_re=%b c_we=%b", c, busy0, a_re0, c_we0);
                checks++;
                if ({busy0, done0, a_re0, b_re0, mac_en0, mac_clr0, c_we0, a_addr0, b_addr0, c_addr0, perf0} !== '0) begin
                    errors++;
                    $display("FAIL midrst_zero c=%0d got busy=%b a_re=%b mac_en=%b c_we=%b a=%0d perf=%0d exp all 0",
                             c, busy0, a_re0, mac_en0, c_we0, a_addr0, perf0);
                end
            end else if (c > 41) begin
                checks++;
                if (c_we0 !== 1'b0 || busy0 !== 1'b0) begin
                    errors++;
                    $display("FAIL midrst_idle c=%0d got c_we=%b busy=%b exp 0 0", c, c_we0, busy0);
                end
            end
        end
        rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            start0 = (t == 0);
            @(posedge clk);
            #1;
            c = t + 1;
            if (c == 1) begin
                $display("restart c=%0d a_re=%b a=%0d b=%0d", c, a_re0, a_addr0, b_addr0);
                checks++;
                if ({a_re0, a_addr0, b_addr0} !== {1'b1, AW0'(0), AW0'(0)}) begin
                    errors++;
                    $display("FAIL restart_issue got a_re=%b a=%0d b=%0d exp 1 0 0", a_re0, a_addr0, b_addr0);
                end
            end
            if (c == 6) begin
                $display("restart c=%0d c_we=%b c_addr=%0d", c, c_we0, c_addr0);
                checks++;
                if ({c_we0, c_addr0} !== {1'b1, AW0'(0)}) begin
                    errors++;
                    $display("FAIL restart_write got c_we=%b c_addr=%0d exp 1 0", c_we0, c_addr0);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_latency_sweep;
        int c, e, p;
        bit in_run, ex_are, ex_men, ex_clr, ex_we;
        for (int t = 0; t < 27; t++) begin
            start1 = (t == 0);
            @(posedge clk);
            #1;
            c = t + 1;
            e = (c - 1) / 6;
            p = (c - 1) % 6;
            in_run = (c <= 24);
            ex_are = in_run && (p < 2);
            ex_men = in_run && (p >= 3) && (p <= 4);
            ex_clr = in_run && (p == 3);
            ex_we  = in_run && (p == 5);
            checks++;
            if ({busy1, done1, a_re1, b_re1, mac_en1, mac_clr1, c_we1} !==
                {in_run, (c == 25), ex_are, ex_are, ex_men, ex_clr, ex_we}) begin
                errors++;
                $display("FAIL lat_ctrl c=%0d got=%b exp=%b", c,
                         {busy1, done1, a_re1, b_re1, mac_en1, mac_clr1, c_we1},
                         {in_run, (c == 25), ex_are, ex_are, ex_men, ex_clr, ex_we});
            end
            if (ex_are) begin
                checks++;
                if (a_addr1 !== AW1'((e / 2) * 2 + p) || b_addr1 !== AW1'(p * 2 + e % 2)) begin
                    errors++;
                    $display("FAIL lat_addr c=%0d got a=%0d b=%0d exp a=%0d b=%0d", c,
                             a_addr1, b_addr1, (e / 2) * 2 + p, p * 2 + e % 2);
                end
            end
            if (ex_we) begin
                $display("lat write c=%0d c_addr=%0d", c, c_addr1);
                checks++;
                if (c_addr1 !== AW1'(e)) begin
                    errors++;
                    $display("FAIL lat_caddr c=%0d got=%0d exp=%0d", c, c_addr1, e);
                end
            end
        end
        do_reset();
    endtask

    task automatic test_back_to_back;
        int c, exp_perf;
        start0 = 1'b1;
        for (int t = 0; t < 101; t++) begin
            @(posedge clk);
            #1;
            c = t + 1;
            if (c == 97) begin
                checks++;
                if ({done0, busy0} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_done c=%0d got done,busy=%b exp=10", c, {done0, busy0});
                end
            end
            if (c == 98) begin
                checks++;
                if ({done0, busy0, a_re0} !== 3'b000) begin
                    errors++;
                    $display("FAIL b2b_idle c=%0d got done,busy,a_re=%b exp=000", c, {done0, busy0, a_re0});
                end
            end
            if (c == 99) begin
                $display("b2b c=%0d busy=%b a_re=%b a=%0d b=%0d perf=%0d", c, busy0, a_re0, a_addr0, b_addr0, perf0);
                checks++;
                if ({busy0, a_re0, a_addr0, b_addr0} !== {2'b11, AW0'(0), AW0'(0)}) begin
                    errors++;
                    $display("FAIL b2b_reissue c=%0d got busy=%b a_re=%b a=%0d b=%0d exp 1 1 0 0",
                             c, busy0, a_re0, a_addr0, b_addr0);
                end
            end
            if (c == 98 || c == 99 || c == 101) begin
`ifdef MM_CTRL_PERF_EN
                exp_perf = (c == 98) ? 96 : c - 99;
`else
                exp_perf = 0;
`endif
                checks++;
                if (perf0 !== 16'(exp_perf)) begin
                    errors++;
                    $display("FAIL b2b_perf c=%0d got=%0d exp=%0d", c, perf0, exp_perf);
                end
            end
        end
        start0 = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_element();
        test_full_run(0, 0, "full");
        test_start_while_busy();
        test_reset_mid_run();
        test_latency_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
